score_ssd_driver: RTL



---
 rtl/score_ssd_driver_pkg.sv | 60 ++++++
 rtl/score_ssd_driver_if.sv | 20 ++
 rtl/score_ssd_driver_bin2bcd_seq.sv | 62 ++++++
 rtl/score_ssd_driver.sv | 109 ++++++++++
 4 files changed

// File: rtl/score_ssd_driver_pkg.sv
// Shared constants, FSM encoding and helpers for the score seven-segment driver.
package score_ssd_driver_pkg;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned BIN_W  = 16;
   localparam int unsigned BCD_W  = 20;
   localparam int unsigned SEG_W  = 7;
   localparam int unsigned ITER_W = 5;

   // Active-low segment codes, {a,b,c,d,e,f,g} MSB to LSB
   localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   typedef logic [DIGITS-1:0][3:0] digits_t;

   // BCD digit to active-low segment pattern; non-decimal codes go dark
   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: add 3 to every nibble that is 5 or more
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int unsigned k = 0; k < BCD_W / 4; k++) begin
         if (r[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_ssd_driver_if.sv
// Score input and display-side signals of the seven-segment driver.
interface score_ssd_driver_if
   import score_ssd_driver_pkg::*;
;
   logic [BIN_W-1:0]  display_number;
   logic [DIGITS-1:0] anode;
   logic [SEG_W-1:0]  ssd_out;
   logic              busy;
   logic              overflow;

   modport master (
      output display_number,
      input  anode, ssd_out, busy, overflow
   );

   modport slave (
      input  display_number,
      output anode, ssd_out, busy, overflow
   );
endinterface

// File: rtl/score_ssd_driver_bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (one shift per clock).
module score_ssd_driver_bin2bcd_seq
   import score_ssd_driver_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd_out
);

   state_t                   r_state;
   logic [BCD_W+BIN_W-1:0]   r_shift;
   logic [ITER_W-1:0]        r_iter;

   // Conversion FSM: capture in IDLE, 16 dabble steps in CONV, one COMMIT cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_iter  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_shift <= {BCD_W'(0), bin_in};
                  r_iter  <= ITER_W'(BIN_W);
                  busy    <= 1'b1;
                  r_state <= CONV;
               end
            end
            CONV: begin
               r_shift <= {dabble_adjust(r_shift[BCD_W+BIN_W-1 -: BCD_W]),
                           r_shift[BIN_W-1:0]} << 1;
               r_iter  <= r_iter - ITER_W'(1);
               if (r_iter == ITER_W'(1)) begin
                  r_state <= COMMIT;
                  done    <= 1'b1;
               end
            end
            COMMIT: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bcd_out = r_shift[BCD_W+BIN_W-1 -: BCD_W];

endmodule

// File: rtl/score_ssd_driver.sv
// Score display driver: change detection, BCD conversion, saturation and 4-digit scan.
module score_ssd_driver
   import score_ssd_driver_pkg::*;
#(
   parameter int unsigned SCAN_DIV_BITS = 18,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic              clk,
   input  logic              rst,
   score_ssd_driver_if.slave if_ssd
);

   localparam bit BLANK_EN = (BLANK_LEADING != 0);

   logic [BIN_W-1:0]         r_last_value;
   logic [BIN_W-1:0]         r_capt;
   logic                     r_force_conv;
   digits_t                  r_digits;
   logic                     r_overflow;
   logic [SCAN_DIV_BITS-1:0] r_scan_cnt;
   logic [DIGITS-1:0]        r_anode;
   logic [SEG_W-1:0]         r_ssd;

   logic                     w_start;
   logic                     w_busy;
   logic                     w_done;
   logic [BCD_W-1:0]         w_bcd;
   logic [1:0]               w_sel;
   logic [3:0]               w_digit;
   logic                     w_blank;
   logic [DIGITS-1:0]        w_anode;

   // The converter is idle exactly when busy is low
   assign w_start = !w_busy &&
                    ((if_ssd.display_number != r_last_value) || r_force_conv);

   score_ssd_driver_bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .start   (w_start),
      .bin_in  (if_ssd.display_number),
      .busy    (w_busy),
      .done    (w_done),
      .bcd_out (w_bcd)
   );

   // Track the converted value and commit saturated digits when conversion ends
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_force_conv <= 1'b1;
         r_last_value <= '0;
         r_capt       <= '0;
         r_digits     <= '0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_start) begin
            r_capt       <= if_ssd.display_number;
            r_force_conv <= 1'b0;
         end
         if (w_done) begin
            r_last_value <= r_capt;
            if (w_bcd[BCD_W-1 -: 4] != 4'd0) begin
               r_digits   <= {DIGITS{4'd9}};
               r_overflow <= 1'b1;
            end else begin
               r_digits   <= w_bcd[DIGITS*4-1:0];
               r_overflow <= 1'b0;
            end
         end
      end
   end

   assign w_sel   = r_scan_cnt[SCAN_DIV_BITS-1 -: 2];
   assign w_digit = r_digits[w_sel];
   assign w_anode = ~(4'b0001 << w_sel);

   // Leading-zero blanking: a digit goes dark when it and all digits above are zero
   always_comb begin
      w_blank = 1'b0;
      if (BLANK_EN && !r_overflow) begin
         case (w_sel)
            2'd3:    w_blank = (r_digits[3] == 4'd0);
            2'd2:    w_blank = (r_digits[3] == 4'd0) && (r_digits[2] == 4'd0);
            2'd1:    w_blank = (r_digits[3] == 4'd0) && (r_digits[2] == 4'd0) &&
                               (r_digits[1] == 4'd0);
            default: w_blank = 1'b0;
         endcase
      end
   end

   // Free-running scan counter with registered anode/segment outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scan_cnt <= '0;
         r_anode    <= 4'b1111;
         r_ssd      <= SEG_BLANK;
      end else begin
         r_scan_cnt <= r_scan_cnt + SCAN_DIV_BITS'(1);
         r_anode    <= w_anode;
         r_ssd      <= w_blank ? SEG_BLANK : seg_decode(w_digit);
      end
   end

   assign if_ssd.anode    = r_anode;
   assign if_ssd.ssd_out  = r_ssd;
   assign if_ssd.busy     = w_busy;
   assign if_ssd.overflow = r_overflow;

endmodule
